// File: rtl/vram_arbiter_pkg.sv
// Shared types and default constants for the VRAM port arbiter.
//   arb_state_e : arbiter FSM states
//   DEF_*       : default parameter values used by vram_arbiter
package vram_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH    = 16;
  localparam int unsigned DEF_DATA_WIDTH    = 16;
  localparam int unsigned DEF_ACCESS_CYCLES = 2;
  localparam int unsigned DEF_MPU_MAX_WAIT  = 4;
  localparam int unsigned BE_WIDTH          = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REN  = 2'd1,
    ST_MPU  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vram_wait_counter.sv
// Saturating starvation counter: counts renderer grants made while the MPU
// is pending and flags when the MPU must be served next.
//   clk, rst_n  : clock, async active-low reset
//   inc         : count one renderer grant (ignored at the limit)
//   clr         : clear on an MPU grant (wins over inc)
//   at_limit_c  : count has reached MAX_WAIT (combinational)
module vram_wait_counter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit_c
);

  localparam int unsigned W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] count_q;

  assign at_limit_c = (count_q >= W'(MAX_WAIT));

  // Count register: clear has priority, increment saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !at_limit_c) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Clocked arbiter for the single external VRAM port, shared between the MPU
// bus and the renderer. Grants whole fixed-length accesses with registered
// strobes; renderer has priority, bounded by a starvation counter.
//   clk, _reset                      : clock, async active-low reset
//   _mpu_en/_mpu_rd/_mpu_wr/_mpu_be  : MPU request, direction, byte enables
//   mpu_addr, mpu_data_in            : MPU address / write data
//   mpu_rd_data, mpu_ready           : MPU read data, done (held until _mpu_en high)
//   ren_req, ren_addr                : renderer read request (level) / address
//   ren_ack, ren_data                : renderer one-cycle ack / read data
//   _vram_en/_vram_rd/_vram_wr/_vram_be, vram_addr : registered VRAM controls
//   vram_data_out, vram_data_oe, vram_data_in      : VRAM data bus halves
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int unsigned MPU_MAX_WAIT  = DEF_MPU_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  _mpu_en,
  input  logic                  _mpu_rd,
  input  logic                  _mpu_wr,
  input  logic [BE_WIDTH-1:0]   _mpu_be,
  input  logic [ADDR_WIDTH-1:0] mpu_addr,
  input  logic [DATA_WIDTH-1:0] mpu_data_in,
  output logic [DATA_WIDTH-1:0] mpu_rd_data,
  output logic                  mpu_ready,
  input  logic                  ren_req,
  input  logic [ADDR_WIDTH-1:0] ren_addr,
  output logic                  ren_ack,
  output logic [DATA_WIDTH-1:0] ren_data,
  output logic                  _vram_en,
  output logic                  _vram_rd,
  output logic                  _vram_wr,
  output logic [BE_WIDTH-1:0]   _vram_be,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0] vram_data_out,
  output logic                  vram_data_oe,
  input  logic [DATA_WIDTH-1:0] vram_data_in
);

  localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vram_en_q, vram_en_d;
  logic                  vram_rd_q, vram_rd_d;
  logic                  vram_wr_q, vram_wr_d;
  logic [BE_WIDTH-1:0]   vram_be_q, vram_be_d;
  logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  oe_q, oe_d;
  logic                  ren_ack_q, ren_ack_d;
  logic [DATA_WIDTH-1:0] ren_data_q, ren_data_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mpu_rd_data_q, mpu_rd_data_d;

  logic mpu_pending;
  logic wait_inc;
  logic wait_clr;
  logic wait_at_limit;

  // done blocks re-issue until the MPU releases _mpu_en
  assign mpu_pending = ~_mpu_en & ~done_q & (~_mpu_rd | ~_mpu_wr);

  vram_wait_counter #(
    .MAX_WAIT (MPU_MAX_WAIT)
  ) u_wait_counter (
    .clk        (clk),
    .rst_n      (_reset),
    .inc        (wait_inc),
    .clr        (wait_clr),
    .at_limit_c (wait_at_limit)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    vram_en_d     = vram_en_q;
    vram_rd_d     = vram_rd_q;
    vram_wr_d     = vram_wr_q;
    vram_be_d     = vram_be_q;
    vram_addr_d   = vram_addr_q;
    wdata_d       = wdata_q;
    oe_d          = oe_q;
    ren_ack_d     = 1'b0;
    ren_data_d    = ren_data_q;
    done_d        = _mpu_en ? 1'b0 : done_q;
    mpu_rd_data_d = mpu_rd_data_q;
    wait_inc      = 1'b0;
    wait_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ren_req && (!mpu_pending || !wait_at_limit)) begin
          state_d     = ST_REN;
          cnt_d       = CNT_W'(ACCESS_CYCLES);
          vram_en_d   = 1'b0;
          vram_rd_d   = 1'b0;
          vram_wr_d   = 1'b1;
          vram_be_d   = '0;
          vram_addr_d = ren_addr;
          oe_d        = 1'b0;
          wait_inc    = mpu_pending;
        end else if (mpu_pending) begin
          // rd and wr both low counts as a write
          state_d     = ST_MPU;
          cnt_d       = CNT_W'(ACCESS_CYCLES);
          vram_en_d   = 1'b0;
          vram_rd_d   = ~_mpu_wr;
          vram_wr_d   = _mpu_wr;
          vram_be_d   = _mpu_be;
          vram_addr_d = mpu_addr;
          oe_d        = ~_mpu_wr;
          if (!_mpu_wr) begin
            wdata_d = mpu_data_in;
          end
          wait_clr    = 1'b1;
        end
      end

      ST_REN, ST_MPU: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_IDLE;
          vram_en_d = 1'b1;
          vram_rd_d = 1'b1;
          vram_wr_d = 1'b1;
          vram_be_d = '1;
          oe_d      = 1'b0;
          if (state_q == ST_REN) begin
            ren_data_d = vram_data_in;
            ren_ack_d  = 1'b1;
          end else begin
            if (!vram_rd_q) begin
              mpu_rd_data_d = vram_data_in;
            end
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      vram_en_q     <= 1'b1;
      vram_rd_q     <= 1'b1;
      vram_wr_q     <= 1'b1;
      vram_be_q     <= '1;
      vram_addr_q   <= '0;
      wdata_q       <= '0;
      oe_q          <= 1'b0;
      ren_ack_q     <= 1'b0;
      ren_data_q    <= '0;
      done_q        <= 1'b0;
      mpu_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vram_en_q     <= vram_en_d;
      vram_rd_q     <= vram_rd_d;
      vram_wr_q     <= vram_wr_d;
      vram_be_q     <= vram_be_d;
      vram_addr_q   <= vram_addr_d;
      wdata_q       <= wdata_d;
      oe_q          <= oe_d;
      ren_ack_q     <= ren_ack_d;
      ren_data_q    <= ren_data_d;
      done_q        <= done_d;
      mpu_rd_data_q <= mpu_rd_data_d;
    end
  end

  assign _vram_en      = vram_en_q;
  assign _vram_rd      = vram_rd_q;
  assign _vram_wr      = vram_wr_q;
  assign _vram_be      = vram_be_q;
  assign vram_addr     = vram_addr_q;
  assign vram_data_out = wdata_q;
  assign vram_data_oe  = oe_q;
  assign ren_ack       = ren_ack_q;
  assign ren_data      = ren_data_q;
  assign mpu_ready     = done_q;
  assign mpu_rd_data   = mpu_rd_data_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Clocked arbiter that shares the single external VRAM port between the MPU bus and the Renderer, replacing the combinational MPU-override mux at the top level. It grants whole, fixed-length accesses and drives registered VRAM strobes, address and write data. Renderer requests have priority, and a wait counter bounds how long the MPU can be starved. The top level keeps the `vram_data` tristate buffer and connects it to `vram_data_out`, `vram_data_oe` and `vram_data_in`.

## Interface
Parameters:
- ADDR_WIDTH, 16, VRAM/MPU address width
- DATA_WIDTH, 16, VRAM data width
- ACCESS_CYCLES, 2, cycles the strobes stay asserted per access (≥1)
- MPU_MAX_WAIT, 4, maximum consecutive renderer grants while the MPU is pending (≥1)

Ports:
- clk  in  1  system clock
- _reset  in  1  asynchronous, active-low reset
- _mpu_en  in  1  MPU access request (active low)
- _mpu_rd  in  1  MPU read (active low)
- _mpu_wr  in  1  MPU write (active low)
- _mpu_be  in  2  MPU byte enables (active low)
- mpu_addr  in  ADDR_WIDTH  MPU address
- mpu_data_in  in  DATA_WIDTH  MPU write data
- mpu_rd_data  out  DATA_WIDTH  captured read data
- mpu_ready  out  1  access done; held until `_mpu_en` rises
- ren_req  in  1  renderer read request (level)
- ren_addr  in  ADDR_WIDTH  renderer address
- ren_ack  out  1  one-cycle pulse; `ren_data` is valid
- ren_data  out  DATA_WIDTH  renderer read data
- _vram_en, _vram_rd, _vram_wr  out  1 each  registered VRAM strobes
- _vram_be  out  2  registered byte enables
- vram_addr  out  ADDR_WIDTH  registered address
- vram_data_out  out  DATA_WIDTH  write data
- vram_data_oe  out  1  drive `vram_data` (high only on MPU writes)
- vram_data_in  in  DATA_WIDTH  VRAM read data

## Operation
States:
- IDLE: all strobes high, `vram_data_oe` = 0. Arbitration happens here.
- REN: renderer access in progress.
- MPU: MPU access in progress.

Request definitions:
- MPU pending = `~_mpu_en & ~done & (~_mpu_rd | ~_mpu_wr)`.
- `done` is set when an MPU access completes and cleared when `_mpu_en` is high.
- If `_mpu_rd` and `_mpu_wr` are both low, the access is treated as a write.

Arbitration in IDLE:
- If `ren_req` is high and either the MPU is not pending or `wait_cnt` < MPU_MAX_WAIT, go to REN.
- Otherwise, if the MPU is pending, go to MPU.
- `wait_cnt` increments on each REN grant made while the MPU is pending. It clears on every MPU grant.

At the grant edge, latch address, byte enables, direction and write data. Renderer accesses use `_vram_be` = 2'b00 and read only.

Access states:
- A down-counter runs for ACCESS_CYCLES cycles.
- On the last edge, capture `vram_data_in` on reads, set `ren_ack` or `done`/`mpu_ready`, and return to IDLE.

Read data is held until the next capture for the same requester. `mpu_ready` = `done`. A new MPU access requires `_mpu_en` to go high and then low again.

## Timing
- Reset (asynchronous, immediate):
  - outputs: strobes = 1, `_vram_be` = 2'b11, `vram_addr` = 0, `vram_data_out` = 0, `vram_data_oe` = 0, `ren_ack` = 0, `mpu_ready` = 0, `mpu_rd_data` = 0, `ren_data` = 0
  - internal: state = IDLE, `wait_cnt` = 0
- Reset mid-access aborts the access with no ack or ready. The requester must reissue.
- Grant at edge G: strobes are low for cycles G..G+ACCESS_CYCLES-1.
- Data is captured and `ren_ack`/`mpu_ready` rise at edge G+ACCESS_CYCLES.
- IDLE lasts at least one cycle (bus turnaround), so the next grant is no earlier than G+ACCESS_CYCLES+1. Peak throughput is one access per ACCESS_CYCLES+1 cycles.
- `vram_data_oe` is high exactly while `_vram_wr` is low.
- Requests arriving during an access wait for IDLE. Inputs changing mid-access have no effect.
- Simultaneous new requests from both sides: the renderer wins unless starved (see Operation).

## Structure
- `vram_arbiter_pkg`: state enum (IDLE, REN, MPU) and default parameter constants.
- One sub-module, `vram_wait_counter`: saturating starvation counter with inc/clear inputs and an at-limit flag. Width is `$clog2(MPU_MAX_WAIT+1)`.

## Test plan
- Reset released, `ren_req` high, `ren_addr` = 16'h0123, `vram_data_in` = 16'hBEEF, defaults → `_vram_rd` low for 2 cycles, `ren_ack` pulse with `ren_data` = 16'hBEEF; next grant 3 cycles after the first.
- MPU write to 16'h4000, data 16'h1234, `_mpu_be` = 2'b10 → `_vram_wr` low 2 cycles with `vram_data_oe` = 1, `vram_data_out` = 16'h1234, `_vram_be` = 2'b10; `mpu_ready` holds until `_mpu_en` rises; no second write while `_mpu_en` stays low.
- `ren_req` held high continuously, MPU read pending → exactly 4 renderer grants, then the MPU grant, then the renderer resumes; `wait_cnt` returns to 0.
- Both requests arrive in the same cycle with `wait_cnt` = 0 → renderer granted first; MPU completes 3 cycles later.
- `_reset` asserted during the first cycle of an MPU write → strobes high and `vram_data_oe` = 0 immediately; `mpu_ready` never rises; reissue after reset completes normally.
